// File: rtl/alu_seq_pkg.sv
// Shared types for the hardwired ALU instruction sequencer: FSM state
// encoding, opcode values, IR field positions and the opcode-to-ALU-code table.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_HALT = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6
    } seq_state_e;

    // IR field positions (opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15])
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_LSB = 23;
    localparam int RB_LSB = 19;
    localparam int RC_LSB = 15;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef struct packed {
        logic       valid;  // opcode is a 3-register ALU operation
        logic [4:0] code;   // ALUControl value for that operation
    } alu_decode_t;

    // Maps an opcode to its ALU function code; valid=0 for anything that is not an ALU op.
    function automatic alu_decode_t alu_decode(input logic [4:0] op);
        alu_decode_t d;
        d.valid = 1'b1;
        d.code  = 5'd0;
        case (op)
            OP_ADD:  d.code = 5'd2;
            OP_SUB:  d.code = 5'd3;
            OP_AND:  d.code = 5'd0;
            OP_OR:   d.code = 5'd1;
            OP_ROR:  d.code = 5'd7;
            OP_ROL:  d.code = 5'd8;
            OP_SHR:  d.code = 5'd4;
            OP_SHRA: d.code = 5'd5;
            OP_SHL:  d.code = 5'd6;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Converts a 4-bit register field plus enable into a one-hot register select.
// Fields that name a register at or beyond NREGS produce no select.
module reg_select_decoder #(
    parameter int NREGS = 16
) (
    input  logic [3:0]       field_i,
    input  logic             en_i,
    output logic [NREGS-1:0] onehot_o
);

    // One bit set for the addressed register while enabled.
    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (en_i && (int'(field_i) == i)) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Hardwired control unit for the phase-1 datapath: fetch through PC/MAR/MDR,
// load IR, decode, and run Ra <- Rb op Rc in six states (T0..T5) plus a HALT
// state. NOP, HALT and an illegal-opcode trap are supported.
// Optional macro ALU_SEQ_INSTR_COUNT_EN adds InstrCount, a wrapping count of
// completed instructions (ALU ops and NOPs).
// Dbg_state exposes the current FSM state for observation.
module alu_instr_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NREGS    = 16,
    parameter int IR_WIDTH = 32
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Start,
    input  logic                Stop,
    input  logic                Mem_ready,
    input  logic [IR_WIDTH-1:0] IR_data,
    output logic                PCout,
    output logic                MARin,
    output logic                IncrementPC,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                ZLOout,
    output logic [NREGS-1:0]    RegIn,
    output logic [NREGS-1:0]    RegOut,
    output logic [4:0]          ALUControl,
    output logic                Run,
    output logic                Illegal,
    output logic [2:0]          Dbg_state
`ifdef ALU_SEQ_INSTR_COUNT_EN
    ,
    output logic [31:0]         InstrCount
`endif
);

    seq_state_e  state_q, state_d;
    logic        stop_q, stop_d;
    logic        illegal_q, illegal_d;
    logic [4:0]  opcode;
    logic [3:0]  ra, rb, rc;
    alu_decode_t dec;
    logic        is_nop;
    logic        stop_pending;
    logic        instr_done;
    logic [3:0]  out_field;
    logic        out_en;
    logic        in_en;
    logic        unused_ir;

    assign opcode       = IR_data[OP_MSB:OP_LSB];
    assign ra           = IR_data[RA_LSB+3:RA_LSB];
    assign rb           = IR_data[RB_LSB+3:RB_LSB];
    assign rc           = IR_data[RC_LSB+3:RC_LSB];
    assign unused_ir    = ^IR_data[RC_LSB-1:0];
    assign dec          = alu_decode(opcode);
    assign is_nop       = (opcode == OP_NOP);
    // A Stop arriving in the boundary cycle itself also counts as latched.
    assign stop_pending = stop_q | Stop;
    // An instruction completes at the end of T5, or at the end of T3 for a NOP.
    assign instr_done   = (state_q == S_T5) || ((state_q == S_T3) && is_nop);

    // State register plus the Stop latch and sticky Illegal flag.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q   <= S_HALT;
            stop_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stop_q    <= stop_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic: fetch, wait for memory, decode, execute, boundary check.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALT: if (Start) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (Mem_ready) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (dec.valid)  state_d = S_T4;
                else if (is_nop) state_d = stop_pending ? S_HALT : S_T0;
                else             state_d = S_HALT;  // HALT opcode or illegal trap
            end
            S_T4:   state_d = S_T5;
            S_T5:   state_d = stop_pending ? S_HALT : S_T0;
            default: state_d = S_HALT;
        endcase
    end

    // Stop latch and Illegal flag updates; Start in HALT clears both and wins over Stop.
    always_comb begin
        stop_d    = stop_q;
        illegal_d = illegal_q;
        if ((state_q == S_HALT) && Start) begin
            stop_d    = 1'b0;
            illegal_d = 1'b0;
        end else begin
            if (Stop) stop_d = 1'b1;
            if ((state_q == S_T3) && !dec.valid && !is_nop && (opcode != OP_HALT)) begin
                illegal_d = 1'b1;
            end
        end
    end

    // Moore strobes decoded from state (T3/T4 also look at the opcode).
    always_comb begin
        PCout       = 1'b0;
        MARin       = 1'b0;
        IncrementPC = 1'b0;
        PCin        = 1'b0;
        Read        = 1'b0;
        MDRin       = 1'b0;
        MDRout      = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        Zin         = 1'b0;
        ZLOout      = 1'b0;
        ALUControl  = 5'd0;
        case (state_q)
            S_T0: begin
                PCout       = 1'b1;
                MARin       = 1'b1;
                IncrementPC = 1'b1;
                Zin         = 1'b1;
            end
            S_T1: begin
                ZLOout = 1'b1;
                PCin   = 1'b1;
                Read   = 1'b1;
                MDRin  = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: Yin = dec.valid;
            S_T4: begin
                Zin        = 1'b1;
                ALUControl = dec.code;
            end
            S_T5: ZLOout = 1'b1;
            default: ;
        endcase
    end

    // Register selects: Rb drives the bus in T3, Rc in T4; Ra loads in T5.
    assign out_field = (state_q == S_T4) ? rc : rb;
    assign out_en    = ((state_q == S_T3) && dec.valid) || (state_q == S_T4);
    assign in_en     = (state_q == S_T5);

    reg_select_decoder #(.NREGS(NREGS)) u_regout_dec (
        .field_i  (out_field),
        .en_i     (out_en),
        .onehot_o (RegOut)
    );

    reg_select_decoder #(.NREGS(NREGS)) u_regin_dec (
        .field_i  (ra),
        .en_i     (in_en),
        .onehot_o (RegIn)
    );

    assign Run       = (state_q != S_HALT);
    assign Illegal   = illegal_q;
    assign Dbg_state = state_q;

`ifdef ALU_SEQ_INSTR_COUNT_EN
    logic [31:0] count_q, count_d;

    // Completed-instruction counter; wraps naturally at 32 bits.
    always_comb begin
        count_d = count_q;
        if (instr_done) count_d = count_q + 32'd1;
    end

    // Counter register.
    always_ff @(posedge Clock) begin
        if (!Reset_n) count_q <= 32'd0;
        else          count_q <= count_d;
    end

    assign InstrCount = count_q;
`else
    logic unused_done;
    assign unused_done = instr_done;
`endif

endmodule
